// File: rtl/slt_cmp_pkg.sv
// Shared constants, state type and decode helpers for the iterative SLT/branch comparator.
// Optional build macro: SLT_CMP_EARLY_EXIT_EN (consumed by slt_cmp_unit).
package slt_cmp_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic MODE_ALU = 1'b0;
    localparam logic MODE_BR  = 1'b1;

    typedef enum logic [1:0] {IDLE, CMP, DONE} cmp_state_t;

    // Equality-only branches report unsigned; their result never looks at LT.
    function automatic logic is_signed(input logic mode, input logic [2:0] f3);
        if (mode == MODE_ALU) return (f3 == F3_SLT);
        return (f3 == F3_BLT) || (f3 == F3_BGE);
    endfunction

    function automatic logic out_map(input logic mode, input logic [2:0] f3,
                                     input logic eq, input logic lt);
        logic res;
        res = 1'b0;
        if (mode == MODE_ALU) begin
            if ((f3 == F3_SLT) || (f3 == F3_SLTU)) res = lt;
        end else begin
            case (f3)
                F3_BEQ:          res = eq;
                F3_BNE:          res = !eq;
                F3_BLT, F3_BLTU: res = lt;
                F3_BGE, F3_BGEU: res = !lt;
                default:         res = 1'b0;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/slt_cmp_if.sv
// Request/result handshake bundle between operand read and writeback/branch resolve.
interface slt_cmp_if #(parameter int WIDTH = 32);

    logic             IN_VALID;
    logic             IN_READY;
    logic             MODE;
    logic [2:0]       FUNC3;
    logic [WIDTH-1:0] RS1_DATA;
    logic [WIDTH-1:0] RS2_DATA;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             OUT;
    logic             EQ;
    logic             LT;

    modport master (
        output IN_VALID, MODE, FUNC3, RS1_DATA, RS2_DATA, OUT_READY,
        input  IN_READY, OUT_VALID, OUT, EQ, LT
    );

    modport slave (
        input  IN_VALID, MODE, FUNC3, RS1_DATA, RS2_DATA, OUT_READY,
        output IN_READY, OUT_VALID, OUT, EQ, LT
    );

endinterface

// File: rtl/slt_cmp_slice.sv
// Combinational unsigned compare of one SLICE-bit operand slice.
module slt_cmp_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    output logic             o_lt,
    output logic             o_eq
);

    assign o_lt = (i_a < i_b);
    assign o_eq = (i_a == i_b);

endmodule

// File: rtl/slt_cmp_unit.sv
// Iterative MSB-first comparator for SLT/SLTU and RV32 branch conditions, SLICE bits per cycle.
// Build macro SLT_CMP_EARLY_EXIT_EN: leave CMP as soon as the first differing slice is seen.
module slt_cmp_unit
    import slt_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic      CLK,
    input  logic      RST_N,
    slt_cmp_if.slave  bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NSLICE - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    cmp_state_t       r_state;
    cmp_state_t       w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_mode;
    logic [2:0]       r_f3;
    logic [IDXW-1:0]  r_idx;
    logic             r_decided;
    logic             r_lt;

    logic [SLICE-1:0] w_slice_a;
    logic [SLICE-1:0] w_slice_b;
    logic             w_slice_lt;
    logic             w_slice_eq;
    logic             w_exit;
    logic [WIDTH-1:0] w_flip;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_eq;
    logic             w_lt;
    logic             w_out;

    assign w_slice_a = r_a[int'(r_idx)*SLICE +: SLICE];
    assign w_slice_b = r_b[int'(r_idx)*SLICE +: SLICE];

    slt_cmp_slice #(.SLICE(SLICE)) u_slice (
        .i_a  (w_slice_a),
        .i_b  (w_slice_b),
        .o_lt (w_slice_lt),
        .o_eq (w_slice_eq)
    );

`ifdef SLT_CMP_EARLY_EXIT_EN
    assign w_exit = (r_idx == '0) || (!r_decided && !w_slice_eq);
`else
    assign w_exit = (r_idx == '0);
`endif

    // Flipping both sign bits turns a signed compare into an unsigned one.
    assign w_flip = is_signed(bus.MODE, bus.FUNC3) ? MSB_MASK : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_eq        = 1'b0;
        w_lt        = 1'b0;
        w_out       = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.IN_VALID) w_next = CMP;
            end
            CMP: begin
                if (w_exit) w_next = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                w_eq        = !r_decided;
                w_lt        = r_decided && r_lt;
                w_out       = out_map(r_mode, r_f3, !r_decided, r_decided && r_lt);
                if (bus.OUT_READY) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Only the most significant differing slice may set the verdict.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_a       <= '0;
            r_b       <= '0;
            r_mode    <= 1'b0;
            r_f3      <= 3'b000;
            r_idx     <= LAST_IDX;
            r_decided <= 1'b0;
            r_lt      <= 1'b0;
        end else if ((r_state == IDLE) && bus.IN_VALID) begin
            r_a       <= bus.RS1_DATA ^ w_flip;
            r_b       <= bus.RS2_DATA ^ w_flip;
            r_mode    <= bus.MODE;
            r_f3      <= bus.FUNC3;
            r_idx     <= LAST_IDX;
            r_decided <= 1'b0;
            r_lt      <= 1'b0;
        end else if (r_state == CMP) begin
            if (!r_decided && !w_slice_eq) begin
                r_decided <= 1'b1;
                r_lt      <= w_slice_lt;
            end
            if (r_idx != '0) r_idx <= r_idx - 1'b1;
        end
    end

    assign bus.IN_READY  = w_in_ready;
    assign bus.OUT_VALID = w_out_valid;
    assign bus.EQ        = w_eq;
    assign bus.LT        = w_lt;
    assign bus.OUT       = w_out;

endmodule

// File: tb/tb_slt_cmp_unit.sv
// Self-checking bench: three slt_cmp_unit builds (SLICE 8, 32, 1) against an arithmetic reference model.
// Honours SLT_CMP_EARLY_EXIT_EN for expected latency.
module tb_slt_cmp_unit;

    logic        clk;
    logic        rstN;
    logic [2:0]  inValid;
    logic [2:0]  outReady;
    logic        mode;
    logic [2:0]  func3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  inReadyV, outValidV, outV, eqV, ltV;

    int vectors;
    int miscompares;

    slt_cmp_if #(.WIDTH(32)) bus8 ();
    slt_cmp_if #(.WIDTH(32)) bus32 ();
    slt_cmp_if #(.WIDTH(32)) bus1 ();

    assign bus8.IN_VALID   = inValid[0];
    assign bus32.IN_VALID  = inValid[1];
    assign bus1.IN_VALID   = inValid[2];
    assign bus8.OUT_READY  = outReady[0];
    assign bus32.OUT_READY = outReady[1];
    assign bus1.OUT_READY  = outReady[2];
    assign bus8.MODE  = mode;  assign bus8.FUNC3  = func3; assign bus8.RS1_DATA  = rs1; assign bus8.RS2_DATA  = rs2;
    assign bus32.MODE = mode;  assign bus32.FUNC3 = func3; assign bus32.RS1_DATA = rs1; assign bus32.RS2_DATA = rs2;
    assign bus1.MODE  = mode;  assign bus1.FUNC3  = func3; assign bus1.RS1_DATA  = rs1; assign bus1.RS2_DATA  = rs2;

    assign inReadyV  = {bus1.IN_READY,  bus32.IN_READY,  bus8.IN_READY};
    assign outValidV = {bus1.OUT_VALID, bus32.OUT_VALID, bus8.OUT_VALID};
    assign outV      = {bus1.OUT,       bus32.OUT,       bus8.OUT};
    assign eqV       = {bus1.EQ,        bus32.EQ,        bus8.EQ};
    assign ltV       = {bus1.LT,        bus32.LT,        bus8.LT};

    slt_cmp_unit #(.WIDTH(32), .SLICE(8))  dut8  (.CLK(clk), .RST_N(rstN), .bus(bus8));
    slt_cmp_unit #(.WIDTH(32), .SLICE(32)) dut32 (.CLK(clk), .RST_N(rstN), .bus(bus32));
    slt_cmp_unit #(.WIDTH(32), .SLICE(1))  dut1  (.CLK(clk), .RST_N(rstN), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sliceOf(input int sel);
        if (sel == 0) return 8;
        if (sel == 1) return 32;
        return 1;
    endfunction

    // Reference: plain signed/unsigned arithmetic plus the branch/ALU truth table.
    task automatic refModel(input int slice, input logic m, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b,
                            output logic o, output logic eq, output logic lt, output int lat);
        logic sgn;
        int   nslice;
        sgn = (m == 1'b0) ? (f3 == 3'b010) : ((f3 == 3'b100) || (f3 == 3'b101));
        eq  = (a == b);
        lt  = sgn ? ($signed(a) < $signed(b)) : (a < b);
        o   = 1'b0;
        if (m == 1'b0) begin
            if (f3 == 3'b010 || f3 == 3'b011) o = lt;
        end else begin
            case (f3)
                3'b000: o = eq;
                3'b001: o = !eq;
                3'b100, 3'b110: o = lt;
                3'b101, 3'b111: o = !lt;
                default: o = 1'b0;
            endcase
        end
        nslice = 32 / slice;
        lat    = nslice + 1;
`ifdef SLT_CMP_EARLY_EXIT_EN
        if (!eq) begin
            int hp;
            hp = 0;
            for (int p = 31; p >= 0; p--) begin
                if (a[p] != b[p]) begin
                    hp = p;
                    break;
                end
            end
            lat = nslice - (hp / slice) + 1;
        end
`endif
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic m, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b, input logic rdy);
        mode          = m;
        func3         = f3;
        rs1           = a;
        rs2           = b;
        inValid[sel]  = 1'b1;
        outReady[sel] = rdy;
    endtask

    // Counts edges from the accepting edge (inclusive) to the edge that raises OUT_VALID.
    task automatic waitResult(input int sel, input string tag, input logic [31:0] a, input logic [31:0] b);
        logic eo, ee, el;
        int   elat, lat;
        refModel(sliceOf(sel), mode, func3, a, b, eo, ee, el, elat);
        checkOutput({tag, "/inReady"}, 32'(inReadyV[sel]), 32'd1);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            inValid[sel] = 1'b0;
        end while (!outValidV[sel] && lat < 100);
        checkOutput({tag, "/latency"}, 32'(lat), 32'(elat));
        checkOutput({tag, "/OUT"}, 32'(outV[sel]), 32'(eo));
        checkOutput({tag, "/EQ"},  32'(eqV[sel]),  32'(ee));
        checkOutput({tag, "/LT"},  32'(ltV[sel]),  32'(el));
    endtask

    task automatic runTxn(input int sel, input string tag, input logic m, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b);
        applyStimulus(sel, m, f3, a, b, 1'b1);
        waitResult(sel, tag, a, b);
        @(posedge clk);
        #1;
        checkOutput({tag, "/handoff"}, 32'(outValidV[sel]), 32'd0);
    endtask

    initial begin
        logic [31:0] a, b, heldOut;
        logic        m;
        logic [2:0]  f3;
        int          sel;
        vectors     = 0;
        miscompares = 0;
        inValid     = 3'b000;
        outReady    = 3'b111;
        mode        = 1'b0;
        func3       = 3'b000;
        rs1         = '0;
        rs2         = '0;
        rstN        = 1'b0;
        #12;
        for (int s = 0; s < 3; s++) begin
            checkOutput("reset/inReady",  32'(inReadyV[s]),  32'd1);
            checkOutput("reset/outValid", 32'(outValidV[s]), 32'd0);
            checkOutput("reset/OUT", 32'(outV[s]), 32'd0);
            checkOutput("reset/EQ",  32'(eqV[s]),  32'd0);
            checkOutput("reset/LT",  32'(ltV[s]),  32'd0);
        end
        rstN = 1'b1;
        @(posedge clk);
        #1;

        runTxn(0, "slt_neg",   1'b0, 3'b010, 32'hFFFF_FFFF, 32'h0000_0001);
        runTxn(0, "sltu_big",  1'b0, 3'b011, 32'hFFFF_FFFF, 32'h0000_0001);
        runTxn(0, "beq_eq",    1'b1, 3'b000, 32'h1234_5678, 32'h1234_5678);
        runTxn(0, "bne_eq",    1'b1, 3'b001, 32'h1234_5678, 32'h1234_5678);
        runTxn(0, "bge_minmax",1'b1, 3'b101, 32'h8000_0000, 32'h7FFF_FFFF);
        runTxn(0, "bltu_low",  1'b1, 3'b110, 32'h0000_0010, 32'h0000_0011);
        runTxn(0, "alu_bad_f3",1'b0, 3'b000, 32'h0000_0001, 32'h0000_0002);
        runTxn(1, "s32_sltu",  1'b0, 3'b011, 32'h0000_0002, 32'h0000_0003);
        runTxn(2, "s1_sltu",   1'b0, 3'b011, 32'h0000_0002, 32'h0000_0003);

        // Backpressure: result must hold while a second request waits outside.
        applyStimulus(0, 1'b0, 3'b011, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        waitResult(0, "bp_first", 32'hFFFF_FFFF, 32'h0000_0001);
        heldOut = 32'(outV[0]);
        applyStimulus(0, 1'b0, 3'b011, 32'h0000_0001, 32'h0000_0002, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checkOutput("bp/outValid", 32'(outValidV[0]), 32'd1);
            checkOutput("bp/inReady",  32'(inReadyV[0]),  32'd0);
            checkOutput("bp/OUT", 32'(outV[0]), 32'd0);
            checkOutput("bp/EQ",  32'(eqV[0]),  32'd0);
            checkOutput("bp/LT",  32'(ltV[0]),  32'd0);
        end
        checkOutput("bp/heldOut", heldOut, 32'd0);
        outReady[0] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp/release_outValid", 32'(outValidV[0]), 32'd0);
        waitResult(0, "bp_second", 32'h0000_0001, 32'h0000_0002);
        @(posedge clk);
        #1;

        // Reset during the second CMP cycle.
        applyStimulus(0, 1'b1, 3'b000, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1);
        @(posedge clk);
        #1;
        inValid[0] = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("rst/busy_inReady", 32'(inReadyV[0]), 32'd0);
        rstN = 1'b0;
        #1;
        checkOutput("rst/async_inReady",  32'(inReadyV[0]),  32'd1);
        checkOutput("rst/async_outValid", 32'(outValidV[0]), 32'd0);
        #10;
        rstN = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            checkOutput("rst/no_stale", 32'(outValidV[0]), 32'd0);
        end
        runTxn(0, "rst_after", 1'b0, 3'b010, 32'h0000_0005, 32'hFFFF_FFFB);

        for (int i = 0; i < 40; i++) begin
            sel = (i % 8 == 7) ? 1 : ((i % 8 == 6) ? 2 : 0);
            a   = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = a;
                2: b = a ^ (32'h1 << $urandom_range(0, 31));
                default: b = a ^ 32'h8000_0000;
            endcase
            m  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            runTxn(sel, "random", m, f3, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/slt_cmp_unit.md
Name: slt_cmp_unit

Overview:
- Parametrised, iterative successor to the single-cycle SLT comparator.
- Compares two WIDTH-bit operands MSB-first, SLICE bits per cycle, signed or unsigned.
- Serves both ALU set-less-than (SLT/SLTU) and branch conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- Sits between operand read and writeback/branch resolve, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32: operand width in bits. Must be a multiple of SLICE.
- SLICE, 8: bits compared per cycle, 1 to WIDTH. NSLICE = WIDTH/SLICE.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  request valid.
- IN_READY  output  1  unit can accept a request.
- MODE  input  1  0 = ALU (SLT/SLTU), 1 = branch.
- FUNC3  input  3  RV32 funct3 of the instruction.
- RS1_DATA  input  WIDTH  operand A.
- RS2_DATA  input  WIDTH  operand B.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  consumer accepts the result.
- OUT  output  1  SLT result bit or branch-taken bit.
- EQ  output  1  A == B.
- LT  output  1  A < B under the selected signedness.

Behaviour:
- Reset (RST_N low, asynchronous):
  - State goes to IDLE.
  - OUT_VALID=0, OUT=0, EQ=0, LT=0, IN_READY=1.
  - Slice counter = NSLICE-1.
  - Reset mid-operation abandons the request with no output.
- States:
  - IDLE: IN_READY=1. IN_VALID & IN_READY captures RS1_DATA, RS2_DATA, MODE and FUNC3 into registers, then moves to CMP.
  - CMP: IN_READY=0. Compares register slice [idx*SLICE +: SLICE] per cycle, with idx counting down from NSLICE-1.
  - DONE: OUT_VALID=1. OUT, EQ and LT stay stable until OUT_READY. DONE & OUT_READY moves to IDLE.
- IN_READY is 1 only in IDLE. There is no acceptance in the same cycle as result hand-off.
- Signedness:
  - Signed for ALU FUNC3=010 and branch FUNC3=100/101.
  - Unsigned for ALU 011 and branch 110/111.
  - Branch 000/001 are equality only; signedness is irrelevant.
  - Signed compare inverts the MSB of both captured operands at capture, then compares unsigned.
- Per CMP cycle:
  - If the slices differ, decided=1 and lt_r = (sliceA < sliceB).
  - Only the first differing slice, the most significant one, sets lt_r. Later slices are ignored once decided.
- Leaving CMP:
  - Exit after the idx==0 cycle, or earlier under EARLY_EXIT_EN.
  - In DONE: EQ = !decided, LT = decided & lt_r.
- OUT mapping:
  - ALU 010/011: LT.
  - Branch 000: EQ. 001: !EQ.
  - Branch 100/110: LT. 101/111: !LT.
  - Any other MODE/FUNC3 combination gives OUT=0, with EQ/LT still computed and the normal latency.
- Latency, acceptance edge to OUT_VALID high:
  - NSLICE+1 cycles: NSLICE CMP cycles plus entry to DONE.
  - SLICE==WIDTH gives 2 cycles.
- Inputs are ignored outside IDLE. Holding IN_VALID high while busy has no effect.
- OUT_READY held high: a result is consumed on its first DONE cycle.

Optional Feature:
- Macro SLT_CMP_EARLY_EXIT_EN.
- Defined: CMP moves to DONE on the cycle after the first differing slice is found.
  - Latency is (NSLICE - idx_first_diff) + 1.
  - Equal operands still take the full NSLICE+1 cycles.
- Undefined: fixed latency NSLICE+1 for all operands, for deterministic scheduling.
- Result values are identical in both builds.

Decomposition:
- Package slt_cmp_pkg:
  - FUNC3 constants (F3_BEQ, F3_BNE, F3_SLT, F3_SLTU, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU).
  - MODE constants (MODE_ALU, MODE_BR).
  - State enum cmp_state_t {IDLE, CMP, DONE}.
- One sub-module, slt_cmp_slice: combinational SLICE-bit compare producing lt and eq. It is instantiated once and muxed by idx.

Test Plan (WIDTH=32, SLICE=8 unless noted):
1. MODE=0, FUNC3=010, A=0xFFFFFFFF, B=0x00000001 -> OUT=1, LT=1, EQ=0. Same operands with FUNC3=011 -> OUT=0, LT=0.
2. MODE=1, FUNC3=000 with A=B=0x12345678 -> OUT=1, EQ=1, and OUT_VALID exactly 5 cycles after acceptance in both builds. FUNC3=001 with the same operands -> OUT=0.
3. A=0x80000000, B=0x7FFFFFFF, FUNC3=101 (BGE) -> OUT=0. With SLT_CMP_EARLY_EXIT_EN the latency is 2 cycles; without it the latency is 5.
4. Backpressure: OUT_READY=0 for 10 cycles after OUT_VALID -> OUT/EQ/LT stable and IN_READY=0 throughout. A new IN_VALID during this time is not accepted. The next request is accepted only after the DONE & OUT_READY cycle.
5. Reset mid-operation: assert RST_N=0 during the 2nd CMP cycle -> OUT_VALID=0 and IN_READY=1 immediately (asynchronous). No stale result appears after release.
6. SLICE=32 and SLICE=1 builds with A=0x00000002, B=0x00000003, FUNC3=011 -> OUT=1. Latency is 2 cycles and 33 cycles respectively (no early exit).
